// File: rtl/hpu_pkg.sv
// Shared hypervector-unit definitions: default widths and rotate direction encoding.
package hpu_pkg;

    localparam int HPU_DIM   = 1024;
    localparam int HPU_TAG_W = 8;

    typedef enum logic {
        ROT_RIGHT = 1'b0,
        ROT_LEFT  = 1'b1
    } rot_dir_e;

endpackage

// File: rtl/permute_stage.sv
// One registered barrel-rotator stage: rotates by 0 or SHIFT bits in the requested direction.
module permute_stage
    import hpu_pkg::*;
#(
    parameter int DIM   = HPU_DIM,
    parameter int SHIFT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sel,
    input  rot_dir_e       dir,
    input  logic [DIM-1:0] d,
    output logic [DIM-1:0] q
);

    logic [DIM-1:0] rot_r;
    logic [DIM-1:0] rot_l;
    logic [DIM-1:0] nxt;

    // Right: bit k lands on k-SHIFT; left: bit k lands on k+SHIFT (both mod DIM).
    assign rot_r = {d[SHIFT-1:0], d[DIM-1:SHIFT]};
    assign rot_l = {d[DIM-SHIFT-1:0], d[DIM-1:DIM-SHIFT]};

    always_comb begin
        nxt = d;
        if (sel) begin
            nxt = (dir == ROT_LEFT) ? rot_l : rot_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/permute_pipe.sv
// Pipelined hypervector rotator: log2(DIM) registered stages, per-beat amount/direction/tag,
// single global advance for backpressure.
module permute_pipe
    import hpu_pkg::*;
#(
    parameter  int DIM     = HPU_DIM,
    parameter  int TAG_W   = HPU_TAG_W,
    localparam int SHIFT_W = $clog2(DIM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIM-1:0]     in_data,
    input  logic [SHIFT_W-1:0] in_amt,
    input  logic               in_dir,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIM-1:0]     out_data,
    output logic [TAG_W-1:0]   out_tag
);

    logic           advance;
    logic           vld_pipe  [SHIFT_W:0];
    logic [DIM-1:0] data_pipe [SHIFT_W:0];
    logic [TAG_W-1:0] tag_pipe [SHIFT_W:0];
    rot_dir_e       dir_pipe  [SHIFT_W-1:0];

    assign advance      = !vld_pipe[SHIFT_W] || out_ready;
    assign in_ready     = advance;
    assign vld_pipe[0]  = in_valid;
    assign data_pipe[0] = in_data;
    assign tag_pipe[0]  = in_tag;
    assign dir_pipe[0]  = rot_dir_e'(in_dir);

    for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
        // Amount bits still pending: stage i consumes the LSB and forwards the rest.
        localparam int RW = SHIFT_W - i;
        logic [RW-1:0] amt_in;

        if (i == 0) begin : g_first
            assign amt_in = in_amt;
        end else begin : g_rest
            assign amt_in = g_stage[i-1].g_fwd.amt_q;
        end

        permute_stage #(
            .DIM   (DIM),
            .SHIFT (1 << i)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .sel (amt_in[0]),
            .dir (dir_pipe[i]),
            .d   (data_pipe[i]),
            .q   (data_pipe[i+1])
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe[i+1] <= 1'b0;
                tag_pipe[i+1] <= '0;
            end else if (advance) begin
                vld_pipe[i+1] <= vld_pipe[i];
                tag_pipe[i+1] <= tag_pipe[i];
            end
        end

        if (i < SHIFT_W - 1) begin : g_fwd
            logic [RW-2:0] amt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    amt_q         <= '0;
                    dir_pipe[i+1] <= ROT_RIGHT;
                end else if (advance) begin
                    amt_q         <= amt_in[RW-1:1];
                    dir_pipe[i+1] <= dir_pipe[i];
                end
            end
        end
    end

    assign out_valid = vld_pipe[SHIFT_W];
    assign out_data  = data_pipe[SHIFT_W];
    assign out_tag   = tag_pipe[SHIFT_W];

endmodule

// File: tb/tb_permute_pipe.sv
// Scoreboard bench for permute_pipe: a DIM=16 instance for directed cases and a DIM=1024
// instance for randomized traffic with random backpressure.
module tb_permute_pipe;

    localparam int D16 = 16;
    localparam int DK  = 1024;
    localparam int TW  = 8;

    typedef struct {
        logic [DK-1:0] data;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          iv16 = 1'b0, ir16, idir16 = 1'b0, ov16, or16 = 1'b1;
    logic [D16-1:0] id16 = '0, od16;
    logic [3:0]    ia16 = '0;
    logic [TW-1:0] it16 = '0, ot16;

    logic          ivk = 1'b0, irk, idirk = 1'b0, ovk, ork = 1'b1;
    logic [DK-1:0] idk = '0, odk;
    logic [9:0]    iak = '0;
    logic [TW-1:0] itk = '0, otk;

    exp_t q16[$];
    exp_t qk[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   pops16 = 0;
    int   first_pop = -1;
    int   last_pop = -1;

    always #5 clk = ~clk;

    permute_pipe #(.DIM(D16), .TAG_W(TW)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .in_amt(ia16), .in_dir(idir16), .in_tag(it16), .out_valid(ov16),
        .out_ready(or16), .out_data(od16), .out_tag(ot16)
    );

    permute_pipe #(.DIM(DK), .TAG_W(TW)) dutk (
        .clk(clk), .rst(rst), .in_valid(ivk), .in_ready(irk), .in_data(idk),
        .in_amt(iak), .in_dir(idirk), .in_tag(itk), .out_valid(ovk),
        .out_ready(ork), .out_data(odk), .out_tag(otk)
    );

    // Bit-by-bit reference: right moves bit k to (k-amt) mod dim, left to (k+amt) mod dim.
    function automatic logic [DK-1:0] rot_ref(logic [DK-1:0] d, int amt, logic dir, int dim);
        logic [DK-1:0] r;
        r = '0;
        for (int k = 0; k < dim; k++) begin
            int dst;
            dst = dir ? (k + amt) % dim : (k - amt + dim) % dim;
            r[dst] = d[k];
        end
        return r;
    endfunction

    task automatic chk(string name, logic [DK-1:0] got, logic [DK-1:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", name, got[511:0], want[511:0]);
        end
    endtask

    task automatic mon();
        exp_t e;
        if (!rst && iv16 && ir16) begin
            e.data = rot_ref(DK'(id16), int'(ia16), idir16, D16);
            e.tag  = it16;
            q16.push_back(e);
        end
        if (!rst && ivk && irk) begin
            e.data = rot_ref(idk, int'(iak), idirk, DK);
            e.tag  = itk;
            qk.push_back(e);
        end
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) begin
                chk("spurious16", DK'(ov16), DK'(0));
            end else begin
                e = q16.pop_front();
                chk("data16", DK'(od16), e.data);
                chk("tag16", DK'(ot16), DK'(e.tag));
                pops16++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        if (!rst && ovk && ork) begin
            if (qk.size() == 0) begin
                chk("spuriousk", DK'(ovk), DK'(0));
            end else begin
                e = qk.pop_front();
                chk("datak", odk, e.data);
                chk("tagk", DK'(otk), DK'(e.tag));
            end
        end
    endtask

    task automatic obs();
        @(negedge clk);
        cyc++;
        mon();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [D16-1:0] sd [12];
        logic [3:0]     sa [12];
        logic           sr [12];
        logic           held_ok;
        logic [D16-1:0] held_d;
        logic [TW-1:0]  held_t;
        int             p0;
        int             b;
        int             nsent;

        next();
        next();
        obs();
        chk("rst_ov16", DK'(ov16), DK'(0));
        chk("rst_od16", DK'(od16), DK'(0));
        chk("rst_ot16", DK'(ot16), DK'(0));
        chk("rst_ovk", DK'(ovk), DK'(0));
        chk("rst_odk", odk, DK'(0));
        next();
        rst = 1'b0;
        obs();
        chk("rst_ir16", DK'(ir16), DK'(1));
        next();

        // Single beat, rotate right by 1, then left by 1; exact 4-cycle latency.
        for (int d = 0; d < 2; d++) begin
            iv16 = 1'b1; id16 = 16'h0001; ia16 = 4'd1; idir16 = d[0]; it16 = 8'hA0 + 8'(d);
            obs();
            next();
            iv16 = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                obs();
                chk("lat16", DK'(ov16), DK'(i == 4));
                if (i == 4) chk("one_bit16", DK'(od16), DK'(d == 0 ? 16'h8000 : 16'h0002));
                next();
            end
        end

        // Back-to-back walking one, amounts 0..15 left.
        p0 = pops16; first_pop = -1;
        for (int i = 0; i < 16; i++) begin
            iv16 = 1'b1; id16 = 16'h0001; ia16 = 4'(i); idir16 = 1'b1; it16 = 8'(i);
            obs();
            next();
        end
        iv16 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            obs();
            next();
        end
        chk("b2b_count", DK'(pops16 - p0), DK'(16));
        chk("b2b_span", DK'(last_pop - first_pop), DK'(15));

        // Stall with out_ready low for 6 cycles while input keeps offering beats.
        for (int i = 0; i < 12; i++) begin
            sd[i] = 16'($urandom()); sa[i] = 4'($urandom_range(0, 15)); sr[i] = 1'($urandom_range(0, 1));
        end
        b = 0; held_ok = 1'b0; held_d = '0; held_t = '0;
        for (int n = 0; n < 60 && (b < 12 || q16.size() > 0); n++) begin
            or16 = (n >= 6);
            iv16 = (b < 12);
            if (b < 12) begin
                id16 = sd[b]; ia16 = sa[b]; idir16 = sr[b]; it16 = 8'h40 + 8'(b);
            end
            obs();
            if (ov16 && !or16) begin
                chk("stall_ir16", DK'(ir16), DK'(0));
                if (held_ok) begin
                    chk("stall_data16", DK'(od16), DK'(held_d));
                    chk("stall_tag16", DK'(ot16), DK'(held_t));
                end
                held_ok = 1'b1; held_d = od16; held_t = ot16;
            end
            if (iv16 && ir16) b++;
            next();
        end
        iv16 = 1'b0; or16 = 1'b1;
        chk("stall_sent", DK'(b), DK'(12));
        chk("stall_drain", DK'(q16.size()), DK'(0));

        // Reset with three beats in flight: none may emerge.
        for (int i = 0; i < 3; i++) begin
            iv16 = 1'b1; id16 = 16'h00F0 + 16'(i); ia16 = 4'd3; idir16 = 1'b0; it16 = 8'h80 + 8'(i);
            obs();
            next();
        end
        iv16 = 1'b0; rst = 1'b1;
        obs();
        next();
        rst = 1'b0;
        obs();
        q16.delete();
        chk("rst_mid_ov16", DK'(ov16), DK'(0));
        chk("rst_mid_ir16", DK'(ir16), DK'(1));
        next();
        for (int i = 0; i < 8; i++) begin
            obs();
            chk("rst_flush16", DK'(ov16), DK'(0));
            next();
        end

        // Random DIM=1024 traffic with random in_valid and out_ready.
        nsent = 0;
        for (int n = 0; n < 5000 && (nsent < 300 || qk.size() > 0); n++) begin
            ork   = ($urandom_range(0, 3) != 0);
            ivk   = (nsent < 300) && ($urandom_range(0, 3) != 0);
            for (int w = 0; w < DK / 32; w++) idk[w*32 +: 32] = $urandom();
            iak   = (n % 17 == 0) ? 10'd0 : 10'($urandom_range(0, DK - 1));
            idirk = 1'($urandom_range(0, 1));
            itk   = 8'($urandom());
            obs();
            if (ivk && irk) nsent++;
            next();
        end
        ivk = 1'b0; ork = 1'b1;
        chk("rnd_sent", DK'(nsent), DK'(300));
        chk("rnd_drain", DK'(qk.size()), DK'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/permute_pipe.md
PERMUTE_PIPE -- requirements
Module: permute_pipe

Interface
REQ-001 SHALL have parameter DIM, default 1024: hypervector width in bits; power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 8: width of sideband tag carried alongside data.
REQ-003 SHALL have derived localparam SHIFT_W = clog2(DIM): number of rotate stages and width of the rotation amount.
REQ-004 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: input beat present.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, DIM: hypervector to rotate.
REQ-009 SHALL have port in_amt, input, SHIFT_W: rotation amount, 0..DIM-1.
REQ-010 SHALL have port in_dir, input, 1: 0 = rotate right (bit k moves to bit (k-amt) mod DIM), 1 = rotate left.
REQ-011 SHALL have port in_tag, input, TAG_W: sideband passed through unchanged.
REQ-012 SHALL have port out_valid, output, 1: result beat present.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-014 SHALL have ports out_data (DIM), out_tag (TAG_W), both outputs: rotated vector and its tag.

Function
REQ-015 SHALL implement SHIFT_W registered stages; stage i rotates by 0 or 2^i bits in the direction given by the beat's dir, selected by bit i of the beat's amt.
REQ-016 SHALL carry valid, amt, dir and tag per stage with the data, so every beat uses its own amt/dir/tag.
REQ-017 SHALL have latency exactly SHIFT_W cycles from an accepted input beat to its out_valid when no stall occurs.
REQ-018 SHALL sustain one beat per cycle with out_ready held high.
REQ-019 SHALL define advance = !out_valid | out_ready; all stage registers load only when advance is 1, otherwise hold.
REQ-020 SHALL drive in_ready = advance combinationally; a beat is accepted when in_valid & in_ready.
REQ-021 SHALL insert a bubble (stage-0 valid = 0) when advance = 1 and in_valid = 0; bubbles propagate and never raise out_valid.
REQ-022 SHALL hold out_data and out_tag stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL treat amt = 0 as identity for either dir.
REQ-024 SHALL preserve beat order; no beat dropped or duplicated under any pattern of in_valid/out_ready.
REQ-025 SHALL gate register updates on valid only for the valid bits; data/tag registers of bubble stages are don't-care.

Reset
REQ-026 SHALL clear all stage valid bits and out_valid to 0 on rst = 1 at a clock edge.
REQ-027 SHALL discard in-flight beats when rst asserts mid-operation; in_ready = 1 in the first cycle after rst deasserts.
REQ-028 SHALL reset out_data and out_tag to 0.

Structure
REQ-029 SHALL place DIM default, TAG_W default and the dir encoding (ROT_RIGHT = 0, ROT_LEFT = 1) in shared package hpu_pkg.
REQ-030 SHALL instantiate sub-module permute_stage (parameters DIM, SHIFT; one registered conditional rotate with enable and reset) SHIFT_W times via generate.

Verification
REQ-031 SHALL test DIM=16: in_data=0x0001, amt=1, dir=0 -> out_data=0x8000 after 4 cycles; dir=1 -> 0x0002.
REQ-032 SHALL test DIM=16, back-to-back beats amt=0..15, dir=1, data=0x0001, out_ready=1 -> outputs 0x0001,0x0002,...,0x8000 on consecutive cycles, tags 0..15 in order.
REQ-033 SHALL test stall: out_ready=0 for 6 cycles while in_valid=1 -> in_ready=0 once out_valid=1, out_data stable, no loss after release.
REQ-034 SHALL test rst asserted with 3 beats in flight -> out_valid=0 next cycle, none of the 3 beats emerges.
REQ-035 SHALL test DIM=1024 random data/amt/dir/tag with random out_ready -> scoreboard matches reference rotate and order.
